// File: rtl/bcd_counter_pkg.sv
// Shared constants, state encoding and nibble helper for the BCD counter.
package bcd_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] nib);
    logic [BCD_W-1:0] res;
    if (nib > BCD_MAX) begin
      res = BCD_MAX;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// Combinational single-decade cell: steps one BCD digit up or down and flags rollover.
module bcd_decade
  import bcd_counter_pkg::*;
(
  input  logic [BCD_W-1:0] val,
  input  logic             en,
  input  logic             up,
  output logic [BCD_W-1:0] next,
  output logic             carry_out
);

  // Increment with 9->0 carry, or decrement with 0->9 borrow, when enabled.
  always_comb begin
    next      = val;
    carry_out = 1'b0;
    if (en) begin
      if (up) begin
        if (val >= BCD_MAX) begin
          next      = 4'd0;
          carry_out = 1'b1;
        end else begin
          next      = val + 4'd1;
          carry_out = 1'b0;
        end
      end else begin
        if (val == 4'd0) begin
          next      = BCD_MAX;
          carry_out = 1'b1;
        end else begin
          next      = val - 4'd1;
          carry_out = 1'b0;
        end
      end
    end else begin
      next      = val;
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-decade BCD up/down counter with run/pause control, prescaled stepping,
// clamped parallel load and a registered wrap pulse.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PW-1:0]       r_presc;
  logic [PW-1:0]       w_presc_nxt;
  logic [4*DIGITS-1:0] r_digits;
  logic [4*DIGITS-1:0] w_digits_nxt;
  logic [4*DIGITS-1:0] w_load_clamped;
  logic                r_wrap;
  logic                r_running;
  logic                w_step;
  logic [DIGITS-1:0]   w_en;
  logic [DIGITS-1:0]   w_carry;

  // Next state with priority clear > load > stop > start.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (load) begin
      w_state_nxt = r_state;
    end else if (stop) begin
      case (r_state)
        RUN:     w_state_nxt = PAUSE;
        default: w_state_nxt = r_state;
      endcase
    end else if (start) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = r_state;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_step = (r_state == RUN) && (r_presc == PRESC_LAST) && !clear && !load;

  // Prescaler only advances while staying in RUN; any entry to RUN starts from zero.
  always_comb begin
    w_presc_nxt = PRESC_ZERO;
    if (clear || load) begin
      w_presc_nxt = PRESC_ZERO;
    end else if ((r_state == RUN) && (w_state_nxt == RUN)) begin
      if (r_presc == PRESC_LAST) begin
        w_presc_nxt = PRESC_ZERO;
      end else begin
        w_presc_nxt = r_presc + PRESC_ONE;
      end
    end else begin
      w_presc_nxt = PRESC_ZERO;
    end
  end

  // Clamp each nibble of the load value into the BCD range.
  always_comb begin
    w_load_clamped = {(4*DIGITS){1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      w_load_clamped[4*i +: 4] = clamp_bcd(load_val[4*i +: 4]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      if (g == 0) begin : g_first
        assign w_en[g] = w_step;
      end else begin : g_rest
        assign w_en[g] = w_carry[g-1];
      end
      bcd_decade u_decade (
        .val       (r_digits[4*g +: 4]),
        .en        (w_en[g]),
        .up        (up),
        .next      (w_digits_nxt[4*g +: 4]),
        .carry_out (w_carry[g])
      );
    end
  endgenerate

  // State, prescaler, count and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_presc   <= PRESC_ZERO;
      r_digits  <= {(4*DIGITS){1'b0}};
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= (w_state_nxt == RUN);
      // A carry out of the top decade on a step is exactly the all-9s/all-0s wrap.
      r_wrap    <= w_step && w_carry[DIGITS-1];
      if (clear) begin
        r_digits <= {(4*DIGITS){1'b0}};
      end else if (load) begin
        r_digits <= w_load_clamped;
      end else if (w_step) begin
        r_digits <= w_digits_nxt;
      end else begin
        r_digits <= r_digits;
      end
    end
  end

  assign digits  = r_digits;
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed scenarios followed by random control traffic, each cycle compared against
// an integer-valued reference model of the counter.
module tb_bcd_counter;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int MODULUS  = 10000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        clear;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] digits;
  logic        running;
  logic        wrap;

  int checks;
  int errors;

  // Reference model: count as a plain integer, mode 0=idle 1=run 2=pause.
  int m_cnt;
  int m_mode;
  int m_ticks;
  bit m_wrap;

  bcd_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .digits   (digits),
    .running  (running),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = 16'h0000;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_to_int(input logic [15:0] lv);
    int v;
    int mul;
    int nib;
    v = 0;
    mul = 1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib > 9) nib = 9;
      v = v + nib * mul;
      mul = mul * 10;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  prev;
    bit  stepping;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_ticks = 0; m_wrap = 1'b0;
    end else if (clear) begin
      m_mode = 0; m_cnt = 0; m_ticks = 0; m_wrap = 1'b0;
    end else if (load) begin
      m_cnt = load_to_int(load_val); m_ticks = 0; m_wrap = 1'b0;
    end else begin
      prev = m_mode;
      stepping = (m_mode == 1) && (m_ticks == PRESCALE - 1);
      m_wrap = 1'b0;
      if (stepping) begin
        if (up) begin
          m_wrap = (m_cnt == MODULUS - 1);
          m_cnt = (m_cnt + 1) % MODULUS;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt = (m_cnt + MODULUS - 1) % MODULUS;
        end
      end
      if (stop) begin
        if (m_mode == 1) m_mode = 2;
      end else if (start) begin
        m_mode = 1;
      end
      m_ticks = (prev == 1 && m_mode == 1) ? (m_ticks + 1) % PRESCALE : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("digits", 32'(digits), 32'(to_bcd(m_cnt)));
    chk("running", 32'(running), 32'(m_mode == 1));
    chk("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  initial begin
    logic ok;
    checks = 0; errors = 0;
    m_cnt = 0; m_mode = 0; m_ticks = 0; m_wrap = 1'b0;
    idle_inputs();
    up = 1'b1; load_val = 16'h0000;

    // Reset then a one-cycle start: first step lands PRESCALE cycles later.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("reset_digits", 32'(digits), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    chk("pre_first_step", 32'(digits), 32'h0);
    tick();
    chk("first_step", 32'(digits), 32'h0001);
    chk("first_running", 32'(running), 32'h1);

    // Up-carry through every decade and wrap pulse.
    load = 1'b1; load_val = 16'h9999; tick(); load = 1'b0;
    repeat (4) tick();
    chk("wrap_digits", 32'(digits), 32'h0000);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    tick();
    chk("wrap_one_cycle", 32'(wrap), 32'h0);
    repeat (3) tick();
    chk("after_wrap", 32'(digits), 32'h0001);

    // Down-borrow without wrap.
    up = 1'b0;
    load = 1'b1; load_val = 16'h1000; tick(); load = 1'b0;
    repeat (4) tick();
    chk("borrow_digits", 32'(digits), 32'h0999);
    chk("borrow_nowrap", 32'(wrap), 32'h0);

    // Clamped load wins over start and keeps RUN.
    load = 1'b1; start = 1'b1; load_val = 16'hF3A1; tick(); idle_inputs();
    chk("clamp_digits", 32'(digits), 32'h9391);
    chk("clamp_running", 32'(running), 32'h1);

    // Pause holds, start+stop stays paused, clear+load goes idle.
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (20) tick();
    chk("pause_running", 32'(running), 32'h0);
    start = 1'b1; stop = 1'b1; tick(); idle_inputs();
    chk("tie_running", 32'(running), 32'h0);
    clear = 1'b1; load = 1'b1; load_val = 16'h4321; tick(); idle_inputs();
    chk("clear_load_digits", 32'(digits), 32'h0000);
    repeat (3) tick();

    // Reset on the step cycle at 0459.
    up = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    load = 1'b1; load_val = 16'h0458; tick(); load = 1'b0;
    repeat (4) tick();
    chk("at_0459", 32'(digits), 32'h0459);
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_digits", 32'(digits), 32'h0000);
    chk("rst_mid_running", 32'(running), 32'h0);
    repeat (6) tick();

    // Random control traffic.
    for (int n = 0; n < 800; n++) begin
      rst   = ($urandom_range(63) == 0);
      clear = ($urandom_range(40) == 0);
      load  = ($urandom_range(30) == 0);
      stop  = ($urandom_range(9) == 0);
      start = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) up = ~up;
      load_val = 16'($urandom);
      tick();
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (digits[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      chk("bcd_range", 32'(ok), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
